// File: rtl/tx_arbiter.sv
// tx_arbiter: shares one 32-bit host transmitter port among NUM_REQ word
// producers. One owner is granted at a time. The owner gets a one-cycle send
// strobe and ack for each word, and it can lock the port for multi-word bursts.
// Optional feature: define TX_ARB_ROUND_ROBIN_EN for round-robin arbitration.
// With the macro undefined, arbitration is fixed priority and index 0 wins.
module tx_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_lock,
  input  logic [32*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    ack,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  tx_send,
  output logic [31:0]           tx_data,
  input  logic                  tx_busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT_LSB = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, SEND, GUARD, WAIT} state_t;

  state_t              state;
  state_t              state_next;
  logic [IW-1:0]       owner;
  logic [IW-1:0]       owner_next;
  logic                locked;
  logic                locked_next;
  logic [NUM_REQ-1:0]  grant_next;
  logic [31:0]         word;
  logic [31:0]         word_next;
  logic                send_next;
  logic [NUM_REQ-1:0]  ack_next;
  logic [31:0]         tx_data_next;
  logic                win_valid;
  logic [IW-1:0]       win_idx;
  logic                owner_req;
  logic                owner_lock;
  logic [31:0]         data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
    assign data_arr[g] = req_data[32*g +: 32];
  end

  assign owner_req  = req[owner];
  assign owner_lock = req_lock[owner];

`ifdef TX_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] rr_ptr;
  logic [IW:0]   rr_sum;
  logic [IW-1:0] rr_cand;

  // Round-robin search from rr_ptr upward; iterating downward keeps the first hit
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    rr_sum    = '0;
    rr_cand   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      rr_sum = {1'b0, rr_ptr} + (IW+1)'(i);
      if (rr_sum >= (IW+1)'(NUM_REQ)) begin
        rr_sum = rr_sum - (IW+1)'(NUM_REQ);
      end
      rr_cand = rr_sum[IW-1:0];
      if (req[rr_cand]) begin
        win_valid = 1'b1;
        win_idx   = rr_cand;
      end
    end
  end

  // Pointer moves past the winner only on fresh arbitration, never on locked continuation
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (state == IDLE && !(locked && owner_lock) && win_valid) begin
      rr_ptr <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
    end
  end
`else
  // Fixed priority: the lowest requesting index wins
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[IW'(i)]) begin
        win_valid = 1'b1;
        win_idx   = IW'(i);
      end
    end
  end
`endif

  // State and registered outputs; reset drops everything, including the lock
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      owner   <= '0;
      locked  <= 1'b0;
      grant   <= '0;
      word    <= '0;
      tx_send <= 1'b0;
      ack     <= '0;
      tx_data <= '0;
    end else begin
      state   <= state_next;
      owner   <= owner_next;
      locked  <= locked_next;
      grant   <= grant_next;
      word    <= word_next;
      tx_send <= send_next;
      ack     <= ack_next;
      tx_data <= tx_data_next;
    end
  end

  // Next-state logic: arbitration, word capture, lock tracking and busy handshake
  always_comb begin
    state_next  = state;
    owner_next  = owner;
    locked_next = locked;
    grant_next  = grant;
    word_next   = word;
    case (state)
      IDLE: begin
        if (locked && owner_lock) begin
          if (owner_req) begin
            word_next  = data_arr[owner];
            state_next = SEND;
          end
        end else begin
          locked_next = 1'b0;
          grant_next  = '0;
          if (win_valid) begin
            owner_next = win_idx;
            grant_next = ONE_HOT_LSB << win_idx;
            word_next  = data_arr[win_idx];
            state_next = SEND;
          end
        end
      end
      SEND: begin
        state_next = GUARD;
      end
      GUARD: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (!tx_busy) begin
          if (owner_lock && owner_req) begin
            locked_next = 1'b1;
            word_next   = data_arr[owner];
            state_next  = SEND;
          end else if (owner_lock) begin
            locked_next = 1'b1;
            state_next  = IDLE;
          end else begin
            locked_next = 1'b0;
            grant_next  = '0;
            state_next  = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode: the strobe, ack and word are launched while in SEND
  always_comb begin
    send_next    = (state == SEND);
    ack_next     = send_next ? grant : '0;
    tx_data_next = send_next ? word : tx_data;
  end

endmodule
